// File: rtl/div_sequencer_if.sv
// Request/response bundle between decode/execute and the divide sequencer.
// master = pipeline side issuing requests, slave = the sequencer.
interface div_sequencer_if #(
    parameter int unsigned XLEN = 32
);
    logic            div_start;
    logic [2:0]      div_op;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [4:0]      rd_in;
    logic            flush;
    logic            busy;
    logic            result_valid;
    logic [XLEN-1:0] result;
    logic [4:0]      result_rd;

    modport master (
        output div_start, div_op, rs1_val, rs2_val, rd_in, flush,
        input  busy, result_valid, result, result_rd
    );

    modport slave (
        input  div_start, div_op, rs1_val, rs2_val, rd_in, flush,
        output busy, result_valid, result, result_rd
    );
endinterface

// File: rtl/div_sequencer.sv
// Multi-cycle RISC-V DIV/DIVU/REM/REMU controller: radix-2 restoring divider
// with fast-path handling of divide-by-zero and signed overflow.
module div_sequencer #(
    parameter int unsigned XLEN = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    div_sequencer_if.slave bus
);
    localparam int unsigned CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic            rem_sel_q, rem_sel_d;
    logic            q_neg_q, q_neg_d;
    logic            r_neg_q, r_neg_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [4:0]      result_rd_q, result_rd_d;

    logic            accept;
    logic            is_signed;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, overflow;
    logic [XLEN:0]   rem_sh, diff;
    logic [XLEN-1:0] q_fix, r_fix;

    always_comb begin
        accept    = ((state_q == S_IDLE) || (state_q == S_DONE)) &&
                    bus.div_start && bus.div_op[2] && !bus.flush;
        is_signed = !bus.div_op[0];
        a_neg     = is_signed && bus.rs1_val[XLEN-1];
        b_neg     = is_signed && bus.rs2_val[XLEN-1];
        a_mag     = a_neg ? ('0 - bus.rs1_val) : bus.rs1_val;
        b_mag     = b_neg ? ('0 - bus.rs2_val) : bus.rs2_val;
        div_zero  = (bus.rs2_val == '0);
        overflow  = is_signed && (bus.rs1_val == MIN_NEG) && (bus.rs2_val == '1);

        // One restoring step: shift {rem, quo} left, trial-subtract with a guard bit.
        rem_sh    = {rem_q, quo_q[XLEN-1]};
        diff      = rem_sh - {1'b0, dvs_q};

        q_fix     = q_neg_q ? ('0 - quo_q) : quo_q;
        r_fix     = r_neg_q ? ('0 - rem_q) : rem_q;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        rem_sel_d   = rem_sel_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        rd_d        = rd_q;
        result_d    = result_q;
        result_rd_d = result_rd_q;

        if (bus.flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (!diff[XLEN]) begin
                        rem_d = diff[XLEN-1:0];
                        quo_d = {quo_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_d = rem_sh[XLEN-1:0];
                        quo_d = {quo_q[XLEN-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_ITER) begin
                        state_d = S_FIX;
                    end
                end
                S_FIX: begin
                    result_d    = rem_sel_q ? r_fix : q_fix;
                    result_rd_d = rd_q;
                    state_d     = S_DONE;
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            // Accept overrides the IDLE/DONE defaults above; DONE -> new op is back-to-back issue.
            if (accept) begin
                rd_d      = bus.rd_in;
                rem_sel_d = bus.div_op[1];
                q_neg_d   = a_neg ^ b_neg;
                r_neg_d   = a_neg;
                quo_d     = a_mag;
                dvs_d     = b_mag;
                rem_d     = '0;
                cnt_d     = '0;
                if (div_zero) begin
                    result_d    = bus.div_op[1] ? bus.rs1_val : '1;
                    result_rd_d = bus.rd_in;
                    state_d     = S_DONE;
                end else if (overflow) begin
                    result_d    = bus.div_op[1] ? '0 : MIN_NEG;
                    result_rd_d = bus.rd_in;
                    state_d     = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            rem_sel_q   <= 1'b0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            rd_q        <= '0;
            result_q    <= '0;
            result_rd_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            rem_sel_q   <= rem_sel_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            rd_q        <= rd_d;
            result_q    <= result_d;
            result_rd_q <= result_rd_d;
        end
    end

    // busy includes the accept term so the issuing instruction stalls in its own cycle.
    always_comb begin
        bus.busy         = (state_q == S_RUN) || (state_q == S_FIX) || accept;
        bus.result_valid = (state_q == S_DONE);
        bus.result       = result_q;
        bus.result_rd    = result_rd_q;
    end
endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed corner cases, randomized ops
// against an arithmetic reference model, flush, async reset and back-to-back issue.
module tb_div_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    div_sequencer_if #(.XLEN(32)) bus ();

    div_sequencer #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // A div_start outside IDLE/DONE (and without flush) is an illegal unsampled start.
    assert property (@(posedge clk) disable iff (!rst_n)
        ($past(bus.busy) && !$past(bus.flush) && !bus.result_valid) |-> !(bus.div_start && !bus.flush))
    else begin
        miscompares++;
        $error("FAIL unsampled_start: div_start got 1 while running, required 0");
    end

    function automatic logic [31:0] model_result(input logic [2:0] op, input logic [31:0] a,
                                                 input logic [31:0] b);
        logic [31:0] r;
        if (b == 32'd0)
            r = op[1] ? a : 32'hFFFF_FFFF;
        else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            r = op[1] ? 32'd0 : 32'h8000_0000;
        else if (!op[0])
            r = op[1] ? ($signed(a) % $signed(b)) : ($signed(a) / $signed(b));
        else
            r = op[1] ? (a % b) : (a / b);
        return r;
    endfunction

    function automatic int model_latency(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
        if (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
            return 1;
        return 34;
    endfunction

    task automatic drive_idle();
        bus.div_start = 1'b0;
        bus.div_op    = 3'b000;
        bus.rs1_val   = '0;
        bus.rs2_val   = '0;
        bus.rd_in     = '0;
        bus.flush     = 1'b0;
    endtask

    task automatic drive_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd);
        bus.div_start = 1'b1;
        bus.div_op    = op;
        bus.rs1_val   = a;
        bus.rs2_val   = b;
        bus.rd_in     = rd;
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
        logic [31:0] exp_res;
        int exp_lat, lat, busy_cycles;
        bit seen;
        exp_res = model_result(op, a, b);
        exp_lat = model_latency(op, a, b);
        @(negedge clk);
        drive_req(op, a, b, rd);
        #1;
        busy_cycles = bus.busy ? 1 : 0;
        seen = 0;
        lat = 0;
        for (int k = 1; k <= 60 && !seen; k++) begin
            @(negedge clk);
            if (k == 1) bus.div_start = 1'b0;
            #1;
            if (bus.result_valid) begin
                seen = 1;
                lat = k;
            end else if (bus.busy) begin
                busy_cycles++;
            end
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL %s.timeout: result_valid got 0 after 60 cycles, required 1", name);
        end else begin
            vectors++;
            if (lat !== exp_lat) begin
                miscompares++;
                $display("FAIL %s.latency: got %0d, expected %0d", name, lat, exp_lat);
            end
            vectors++;
            if (bus.result !== exp_res) begin
                miscompares++;
                $display("FAIL %s.result: got %h, expected %h (op=%b a=%h b=%h)", name, bus.result,
                         exp_res, op, a, b);
            end
            vectors++;
            if (bus.result_rd !== rd) begin
                miscompares++;
                $display("FAIL %s.result_rd: got %0d, expected %0d", name, bus.result_rd, rd);
            end
            vectors++;
            if (busy_cycles !== exp_lat || bus.busy !== 1'b0) begin
                miscompares++;
                $display("FAIL %s.busy: got %0d busy cycles (busy=%b in DONE), expected %0d (busy=0)",
                         name, busy_cycles, bus.busy, exp_lat);
            end
            @(negedge clk);
            #1;
            vectors++;
            if (bus.result_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL %s.pulse: result_valid got %b one cycle later, expected 0", name,
                         bus.result_valid);
            end
        end
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset.busy: got %b, expected 0", bus.busy);
        end
        vectors++;
        if (bus.result_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset.result_valid: got %b, expected 0", bus.result_valid);
        end
        vectors++;
        if (bus.result !== 32'd0) begin
            miscompares++;
            $display("FAIL reset.result: got %h, expected 00000000", bus.result);
        end
        vectors++;
        if (bus.result_rd !== 5'd0) begin
            miscompares++;
            $display("FAIL reset.result_rd: got %0d, expected 0", bus.result_rd);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        run_op("divu_100_7", 3'b101, 32'd100, 32'd7, 5'd5);
        run_op("remu_100_7", 3'b111, 32'd100, 32'd7, 5'd6);
        run_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd7);
        run_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd8);
        run_op("rem_7_m2", 3'b110, 32'd7, 32'hFFFF_FFFE, 5'd9);
        run_op("div_123_0", 3'b100, 32'd123, 32'd0, 5'd10);
        run_op("remu_123_0", 3'b111, 32'd123, 32'd0, 5'd11);
        run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
        run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);
        run_op("divu_max_1", 3'b101, 32'hFFFF_FFFF, 32'd1, 5'd31);
        run_op("divu_ovf_pat", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14);
    endtask

    task automatic test_ignored_op();
        int valids;
        bit busy_seen;
        valids = 0;
        busy_seen = 0;
        @(negedge clk);
        drive_req(3'b001, 32'd50, 32'd5, 5'd3);
        #1;
        busy_seen = bus.busy;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.div_start = 1'b0;
            #1;
            if (bus.result_valid) valids++;
            if (bus.busy) busy_seen = 1;
        end
        vectors++;
        if (valids !== 0 || busy_seen !== 1'b0) begin
            miscompares++;
            $display("FAIL ignored_op: got %0d valids busy=%b, expected 0 valids busy=0", valids,
                     busy_seen);
        end
    endtask

    task automatic test_random();
        logic [2:0] op;
        logic [31:0] a, b;
        int sel;
        for (int i = 0; i < 30; i++) begin
            op  = {1'b1, 2'($urandom_range(0, 3))};
            sel = $urandom_range(0, 9);
            a   = $urandom;
            b   = $urandom;
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end else if (sel == 2) b = 32'($urandom_range(1, 15));
            else if (sel == 3) b = -32'($urandom_range(1, 15));
            run_op($sformatf("rand%0d", i), op, a, b, 5'($urandom_range(0, 31)));
        end
    endtask

    task automatic test_flush();
        int valids;
        bit busy_after;
        @(negedge clk);
        drive_req(3'b101, 32'd1000, 32'd3, 5'd9);
        @(negedge clk);
        bus.div_start = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        drive_req(3'b101, 32'd77, 32'd7, 5'd20);
        #1;
        vectors++;
        if (bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL flush.busy_in_run: got %b, expected 1", bus.busy);
        end
        @(negedge clk);
        bus.flush = 1'b0;
        bus.div_start = 1'b0;
        #1;
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL flush.busy_next: got %b, expected 0", bus.busy);
        end
        valids = 0;
        busy_after = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (bus.result_valid) valids++;
            if (bus.busy) busy_after = 1;
        end
        vectors++;
        if (valids !== 0 || busy_after !== 1'b0) begin
            miscompares++;
            $display("FAIL flush.no_result: got %0d valids busy=%b, expected 0 valids busy=0", valids,
                     busy_after);
        end
    endtask

    task automatic test_reset_mid();
        int valids;
        run_op("pre_reset", 3'b101, 32'd999, 32'd10, 5'd21);
        @(negedge clk);
        drive_req(3'b101, 32'hFFFF_FFFF, 32'd3, 5'd17);
        @(negedge clk);
        bus.div_start = 1'b0;
        repeat (14) @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid.ctrl: got busy=%b valid=%b, expected 0 0", bus.busy,
                     bus.result_valid);
        end
        vectors++;
        if (bus.result !== 32'd0 || bus.result_rd !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_mid.data: got result=%h rd=%0d, expected 0 0", bus.result,
                     bus.result_rd);
        end
        @(negedge clk);
        rst_n = 1'b1;
        valids = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (bus.result_valid) valids++;
        end
        vectors++;
        if (valids !== 0) begin
            miscompares++;
            $display("FAIL reset_mid.no_result: got %0d valids, expected 0", valids);
        end
    endtask

    task automatic test_back_to_back();
        int early, lat;
        bit seen;
        logic [31:0] exp_b;
        exp_b = model_result(3'b100, 32'hFFFF_FC18, 32'd7);
        @(negedge clk);
        drive_req(3'b101, 32'd100, 32'd7, 5'd5);
        early = 0;
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            if (k == 1) bus.div_start = 1'b0;
            #1;
            if (bus.result_valid) early++;
        end
        vectors++;
        if (early !== 0) begin
            miscompares++;
            $display("FAIL b2b.early_valid: got %0d, expected 0", early);
        end
        @(negedge clk);
        drive_req(3'b100, 32'hFFFF_FC18, 32'd7, 5'd12);
        #1;
        vectors++;
        if (bus.result_valid !== 1'b1 || bus.result !== 32'd14 || bus.result_rd !== 5'd5 ||
            bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b.a_done: got valid=%b result=%h rd=%0d busy=%b, expected 1 0000000e 5 1",
                     bus.result_valid, bus.result, bus.result_rd, bus.busy);
        end
        seen = 0;
        lat = 0;
        early = 0;
        for (int j = 1; j <= 60 && !seen; j++) begin
            @(negedge clk);
            if (j == 1) bus.div_start = 1'b0;
            #1;
            if (bus.result_valid) begin
                if (j < 34) early++;
                else begin
                    seen = 1;
                    lat = j;
                end
            end
        end
        vectors++;
        if (!seen || lat !== 34 || early !== 0) begin
            miscompares++;
            $display("FAIL b2b.b_latency: got lat=%0d extra_valids=%0d, expected 34 0", lat, early);
        end
        vectors++;
        if (bus.result !== exp_b || bus.result_rd !== 5'd12) begin
            miscompares++;
            $display("FAIL b2b.b_result: got %h rd=%0d, expected %h rd=12", bus.result,
                     bus.result_rd, exp_b);
        end

        // Fast-path ops issued on consecutive cycles.
        @(negedge clk);
        drive_req(3'b100, 32'd5, 32'd0, 5'd3);
        @(negedge clk);
        drive_req(3'b111, 32'd9, 32'd0, 5'd4);
        #1;
        vectors++;
        if (bus.result_valid !== 1'b1 || bus.result !== 32'hFFFF_FFFF || bus.result_rd !== 5'd3 ||
            bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b.fast_a: got valid=%b result=%h rd=%0d busy=%b, expected 1 ffffffff 3 1",
                     bus.result_valid, bus.result, bus.result_rd, bus.busy);
        end
        @(negedge clk);
        bus.div_start = 1'b0;
        #1;
        vectors++;
        if (bus.result_valid !== 1'b1 || bus.result !== 32'd9 || bus.result_rd !== 5'd4 ||
            bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b.fast_b: got valid=%b result=%h rd=%0d busy=%b, expected 1 00000009 4 0",
                     bus.result_valid, bus.result, bus.result_rd, bus.busy);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (bus.result_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b.fast_end: result_valid got %b, expected 0", bus.result_valid);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignored_op();
        test_random();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
